// File: rtl/lcd_pkg.sv
// Shared types, timing defaults and HD44780 command codes for the LCD bus arbiter.
package lcd_pkg;

   localparam int unsigned CNT_W  = 20;
   localparam int unsigned DATA_W = 8;

   localparam int unsigned DEF_T_INIT  = 750000;
   localparam int unsigned DEF_T_SETUP = 2;
   localparam int unsigned DEF_T_PULSE = 12;
   localparam int unsigned DEF_T_HOLD  = 2;
   localparam int unsigned DEF_T_EXEC  = 2000;
   localparam int unsigned DEF_T_LONG  = 80000;

   localparam logic [DATA_W-1:0] CMD_CLEAR        = 8'h01;
   localparam logic [DATA_W-1:0] CMD_HOME         = 8'h02;
   localparam logic [DATA_W-1:0] CMD_FUNCTION_SET = 8'h3C;
   localparam logic [DATA_W-1:0] CMD_DISP_ON      = 8'h0C;
   localparam logic [DATA_W-1:0] CMD_ENTRY_MODE   = 8'h06;
   localparam logic [DATA_W-1:0] CMD_LINE1        = 8'h80;
   localparam logic [DATA_W-1:0] CMD_LINE2        = 8'hC0;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_EXEC  = 3'd5
   } lcd_state_t;

   typedef struct packed {
      logic              rs;
      logic [DATA_W-1:0] data;
   } lcd_xfer_t;

   // Clear/home (and 0x00) need the long execution wait.
   function automatic logic is_long_cmd(input lcd_xfer_t x);
      return (x.rs == 1'b0) && (x.data[7:2] == 6'd0);
   endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Two-requester handshake bundle: requesters drive VALID/RS/DATA, the arbiter answers READY.
interface lcd_bus_arbiter_if;
   import lcd_pkg::*;

   logic              VALID0;
   logic              RS0;
   logic [DATA_W-1:0] DATA0;
   logic              LOCK0;
   logic              VALID1;
   logic              RS1;
   logic [DATA_W-1:0] DATA1;
   logic              READY0;
   logic              READY1;

   modport master (
      output VALID0, RS0, DATA0, LOCK0, VALID1, RS1, DATA1,
      input  READY0, READY1
   );

   modport slave (
      input  VALID0, RS0, DATA0, LOCK0, VALID1, RS1, DATA1,
      output READY0, READY1
   );

endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter that parks at zero; shared by every arbiter state.
module lcd_delay_timer
   import lcd_pkg::*;
#(
   parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         cnt_q <= RESET_VALUE;
      end else if (load) begin
         cnt_q <= load_value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates two requesters onto a write-only HD44780 bus and sequences the E strobe timing.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int unsigned T_INIT  = DEF_T_INIT,
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_PULSE = DEF_T_PULSE,
   parameter int unsigned T_HOLD  = DEF_T_HOLD,
   parameter int unsigned T_EXEC  = DEF_T_EXEC,
   parameter int unsigned T_LONG  = DEF_T_LONG
) (
   input  logic              CLK,
   input  logic              RESETN,
   lcd_bus_arbiter_if.slave  req,
   output logic              OWNER,
   output logic              BUSY,
   output logic              LCD_E,
   output logic              LCD_RS,
   output logic              LCD_RW,
   output logic [DATA_W-1:0] LCD_DATA
);

   localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(T_INIT - 1);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

   lcd_state_t       state_q;
   lcd_state_t       state_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_zero_c;

   logic             lock_active_c;
   logic             grant0_c;
   logic             grant1_c;

   lcd_xfer_t        xfer_q;
   lcd_xfer_t        xfer_d;
   logic             e_q;
   logic             e_d;
   logic             owner_q;
   logic             owner_d;
   logic             lock_q;
   logic             lock_d;
   logic             busy_q;
   logic             busy_d;

   lcd_delay_timer #(
      .RESET_VALUE (LD_INIT)
   ) u_timer (
      .CLK        (CLK),
      .RESETN     (RESETN),
      .load       (tmr_load),
      .load_value (tmr_value),
      .zero_c     (tmr_zero_c)
   );

   // Fixed priority to requester 1 unless requester 0 holds a burst lock.
   always_comb begin
      grant0_c      = 1'b0;
      grant1_c      = 1'b0;
      lock_active_c = lock_q && req.LOCK0 && !owner_q;
      if (state_q == ST_IDLE) begin
         if (lock_active_c) begin
            grant0_c = req.VALID0;
         end else begin
            grant1_c = req.VALID1;
            grant0_c = req.VALID0 && !req.VALID1;
         end
      end
   end

   assign req.READY0 = grant0_c;
   assign req.READY1 = grant1_c;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Each state exits when the shared timer hits zero and reloads it for the next state.
   always_comb begin
      state_d   = state_q;
      tmr_load  = 1'b0;
      tmr_value = '0;
      case (state_q)
         ST_INIT: begin
            if (tmr_zero_c) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (grant0_c || grant1_c) begin
               state_d   = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_value = LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_zero_c) begin
               state_d   = ST_PULSE;
               tmr_load  = 1'b1;
               tmr_value = LD_PULSE;
            end
         end
         ST_PULSE: begin
            if (tmr_zero_c) begin
               state_d   = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_value = LD_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_zero_c) begin
               state_d   = ST_EXEC;
               tmr_load  = 1'b1;
               tmr_value = is_long_cmd(xfer_q) ? LD_LONG : LD_EXEC;
            end
         end
         ST_EXEC: begin
            if (tmr_zero_c) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Next values of the registered outputs; payload only changes on an accept.
   always_comb begin
      xfer_d  = xfer_q;
      owner_d = owner_q;
      lock_d  = lock_q;
      e_d     = (state_d == ST_PULSE);
      busy_d  = (state_d != ST_IDLE);
      if (grant1_c) begin
         xfer_d.rs   = req.RS1;
         xfer_d.data = req.DATA1;
         owner_d     = 1'b1;
         lock_d      = 1'b0;
      end else if (grant0_c) begin
         xfer_d.rs   = req.RS0;
         xfer_d.data = req.DATA0;
         owner_d     = 1'b0;
         lock_d      = req.LOCK0;
      end else if ((state_q == ST_IDLE) && !req.LOCK0) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         xfer_q  <= '0;
         e_q     <= 1'b0;
         owner_q <= 1'b0;
         lock_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         xfer_q  <= xfer_d;
         e_q     <= e_d;
         owner_q <= owner_d;
         lock_q  <= lock_d;
         busy_q  <= busy_d;
      end
   end

   assign OWNER    = owner_q;
   assign BUSY     = busy_q;
   assign LCD_E    = e_q;
   assign LCD_RS   = xfer_q.rs;
   assign LCD_DATA = xfer_q.data;
   assign LCD_RW   = 1'b0;

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter T_INIT, 750000, power-on wait in CLK cycles before the first transfer.
REQ-002 Parameter T_SETUP, 2, cycles RS/DATA stable with E low before the E pulse.
REQ-003 Parameter T_PULSE, 12, cycles E is held high.
REQ-004 Parameter T_HOLD, 2, cycles E is low with RS/DATA still held after the pulse.
REQ-005 Parameter T_EXEC, 2000, post-transfer wait for normal commands and characters.
REQ-006 Parameter T_LONG, 80000, post-transfer wait for clear/home commands.
REQ-007 CLK  in  1  system clock; RESETN  in  1  reset, synchronous, active-low.
REQ-008 VALID0  in  1  low-priority (display refresh) request; RS0  in  1; DATA0  in  8; LOCK0  in  1  hold grant across a burst.
REQ-009 VALID1  in  1  high-priority (event/command) request; RS1  in  1; DATA1  in  8.
REQ-010 READY0, READY1  out  1 each  one-cycle accept strobe for the granted requester.
REQ-011 OWNER  out  1  last granted requester (0/1); BUSY  out  1  high whenever the state is not IDLE.
REQ-012 LCD_E  out  1; LCD_RS  out  1; LCD_RW  out  1  (constant 0, write-only); LCD_DATA  out  8; all registered.

Function
REQ-013 States: INIT, IDLE, SETUP, PULSE, HOLD, EXEC; one shared down-counter times every state.
REQ-014 INIT lasts T_INIT cycles, then IDLE; no READY is asserted in INIT.
REQ-015 In IDLE the grant is fixed-priority: VALID1 wins over VALID0, except while the lock is active.
REQ-016 The lock is active when OWNER=0, LOCK0=1 and the previous transfer was requester 0; while active only VALID0 is granted and VALID1 waits.
REQ-017 When LOCK0 is deasserted, the lock releases at the next IDLE.
REQ-018 Accept: READYx=1 for exactly the IDLE cycle in which VALIDx is granted; RSx/DATAx are captured into LCD_RS/LCD_DATA on that edge; OWNER is updated; next state is SETUP.
REQ-019 SETUP lasts T_SETUP cycles (E=0), PULSE T_PULSE cycles (E=1), HOLD T_HOLD cycles (E=0); LCD_RS/LCD_DATA stay unchanged from accept through the end of HOLD.
REQ-020 EXEC lasts T_LONG cycles if the captured RS=0 and DATA[7:2]=0 (clear 0x01, home 0x02/0x03, 0x00); otherwise T_EXEC cycles. EXEC then goes to IDLE.
REQ-021 Latency: from VALID arriving in IDLE, READY is asserted in the same cycle and the E rising edge occurs T_SETUP+1 cycles later.
REQ-022 Transfer period: 1+T_SETUP+T_PULSE+T_HOLD+exec cycles; back-to-back requests get no extra idle cycle.
REQ-023 VALID dropped before grant: the request is lost silently, and no transfer occurs.
REQ-024 VALIDx/RSx/DATAx are sampled only in IDLE; changes during a transfer have no effect.
REQ-025 Simultaneous VALID0 and VALID1 with the lock inactive: requester 1 is served first, and requester 0 is served in the next IDLE if still valid.
REQ-026 Counter arithmetic: 20-bit unsigned; the load value is N-1; a state exits when the count reaches 0; each state parameter must be >= 1.

Reset
REQ-027 On RESETN=0 at a CLK edge: state INIT, counter loaded with T_INIT-1, LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, READY0=READY1=0, OWNER=0, lock cleared, BUSY=1.
REQ-028 A reset during any transfer aborts it immediately, with E forced low on the same edge; no partial pulse resumes afterwards.

Structure
REQ-029 Shared package lcd_pkg: state encoding, default timing constants, LCD command constants (CLEAR 0x01, HOME 0x02, FUNCTION_SET 0x3C, DISP_ON 0x0C, ENTRY_MODE 0x06, LINE1 0x80, LINE2 0xC0).
REQ-030 One sub-module, lcd_delay_timer: a loadable 20-bit down-counter with a zero flag, instantiated once.

Verification
(Bench parameters: T_INIT=100, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_EXEC=20, T_LONG=800.)
REQ-031 Reset, then VALID1 with RS1=0, DATA1=0x0C held high -> READY1 is seen only at cycle 100; E is high for exactly 4 cycles starting 3 cycles after accept; BUSY is high for 1+2+4+2+20 cycles.
REQ-032 VALID0 and VALID1 asserted together with LOCK0=0 -> READY1 first, READY0 29 cycles later, OWNER goes 1 then 0.
REQ-033 LOCK0=1 with 16 back-to-back requester-0 characters 0x41, and VALID1 raised after the 3rd -> all 16 are served before READY1.
REQ-034 Command 0x01 with RS=0 -> the next READY comes 809 cycles after accept; command 0x41 with RS=1 -> 29 cycles.
REQ-035 RESETN pulsed low during PULSE -> E=0 on the next edge, all outputs reach their reset values, and the bench waits 100 cycles for the next READY.
REQ-036 DATA1 changed from 0x80 to 0xC0 mid-transfer -> LCD_DATA stays 0x80 until the end of HOLD.
